debug_frame_gen: RTL and testbench
==================================

Name: debug_frame_gen

Overview:
Builds the periodic serial-debug text frame in the clk_debug domain and hands it to serial_debug (msg → data, send → send).
- Keeps a free-running decimal timestamp, in tenths of a tick unit, as a cascade of BCD decade counters. No binary-to-BCD conversion.
- Renders the timestamp to ASCII with leading-zero blanking.
- Emits a one-time start-up banner after reset.
- Throttles frames against the serializer's busy flag, counting any frames it drops.

Parameters:
DIGITS, 5, timestamp BCD digits; the last digit is the fractional (tenths) digit; legal range 2..8.
MSG_CHARS, 16, frame length in ASCII characters; must be ≥ DIGITS+7.
DROP_W, 8, width of the saturating drop counter.

Ports:
clk_debug  in  1  frame-rate clock
rst  in  1  reset, synchronous, active-high
en  in  1  run enable; 0 freezes the timestamp and suppresses frames
busy  in  1  serial_debug busy, asynchronous to clk_debug
data  in  16  status word for the optional hex field
msg  out  8*MSG_CHARS  frame; char 0 is at the MSBs, char MSG_CHARS-1 is at the LSBs
send  out  1  frame-valid strobe, high for exactly one clk_debug period
overrun  out  1  sticky: at least one frame dropped since reset
drop_cnt  out  DROP_W  number of dropped frames, saturating

Behaviour:
- Reset applies on the next clk_debug edge while rst=1:
  - timestamp = 0
  - msg = all spaces, with the last char = "\r"
  - send = 0, overrun = 0, drop_cnt = 0
  - busy synchroniser cleared
  - FSM = BANNER
- busy passes through a 2-flop synchroniser (busy_s). Decisions use busy_s, so there is 2 ticks of latency.
- FSM states and transitions:
  - BANNER: on an edge with en=1 and busy_s=0, load the banner "AVIONICS START" into msg, space-padded, last char "\r". Pulse send. Go to RUN. The timestamp does not advance in BANNER. While busy_s=1 in BANNER, wait; this is not counted as a drop.
  - RUN, with en=1 on each edge:
    - busy_s=0: msg ← rendering of the current (pre-increment) timestamp; send=1.
    - busy_s=1: msg holds; send=0; drop_cnt increments, saturating at all-ones; overrun ← 1.
    - In both cases the timestamp increments by 1 LSB (0.1).
  - RUN with en=0: timestamp holds, send=0, no drop counted.
- Timestamp arithmetic: digit d increments when all lower digits are 9. A digit at 9 rolls to 0 and carries. All-9s wraps to all-0s silently; this is not an overrun.
- Frame layout, chars 0..MSG_CHARS-1:
  - Chars 0..DIGITS-2: integer digits. Leading zeros are rendered as space, except the units digit, which always shows.
  - Char DIGITS-1: "."
  - Char DIGITS: tenths digit.
  - Chars up to MSG_CHARS-2: space.
  - Char MSG_CHARS-1: "\r".
- Latency: send and msg update on the same edge, so msg is stable whenever send=1. msg holds between frames.
- rst mid-frame: takes priority over everything. The banner is re-emitted afterwards.

Optional Feature:
DEBUG_HEXFIELD_EN
- Defined: chars DIGITS+1..DIGITS+5 hold " HHHH", the uppercase hex of data sampled on the emitting edge, MS nibble first.
- Undefined: those chars are spaces, and data is unused.

Decomposition:
- Package debug_pkg:
  - CHAR_W=8
  - ASCII constants: SPACE, CR, DOT, ZERO
  - banner string constant
  - FSM state typedef {BANNER, RUN}
  - function nib2hex (4-bit → ASCII)
  - function bcd2char
- Sub-module bcd_decade: one 4-bit digit with inc_in and carry_out. Instanced DIGITS times in a generate chain.

Test Plan:
- Reset, then en=1, busy=0 → tick 1: send=1 with the banner frame; tick 2: "   0.0" + spaces + "\r"; tick 3: "   0.1".
- 100 RUN ticks → frame 100 shows "   9.9", frame 101 shows "  10.0". Checks carry across digits and zero blanking.
- Force the timestamp to 9999.9 by running 99999 ticks → next frame "9999.9", then "   0.0"; overrun stays 0.
- busy=1 for 5 ticks in RUN → after 2 ticks of sync latency, send stays low for 5 ticks; drop_cnt=5; overrun=1; the next frame's timestamp has jumped by 5. Then hold busy for 300 ticks → drop_cnt=255, holding.
- en=0 for 4 ticks → no send, timestamp unchanged. Assert rst for one edge mid-RUN → all outputs at reset values, then the banner is re-sent; busy=1 during BANNER → waits, drop_cnt stays 0.
- With DEBUG_HEXFIELD_EN and data=16'hBEEF → chars 6..10 = " BEEF". Without the macro → spaces.

Source files
------------

// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared constants, FSM state type and character helpers for debug_frame_gen
package debug_pkg;

    localparam int CHAR_W = 8;

    localparam logic [CHAR_W-1:0] SPACE = 8'h20;
    localparam logic [CHAR_W-1:0] CR    = 8'h0D;
    localparam logic [CHAR_W-1:0] DOT   = 8'h2E;
    localparam logic [CHAR_W-1:0] ZERO  = 8'h30;

    localparam int                       BANNER_LEN = 14;
    localparam logic [CHAR_W*BANNER_LEN-1:0] BANNER_STR = "AVIONICS START";

    typedef enum logic {
        BANNER = 1'b0,
        RUN    = 1'b1
    } state_e;

    function automatic logic [CHAR_W-1:0] nib2hex(input logic [3:0] n);
        return (n < 4'd10) ? (ZERO + {4'd0, n}) : (8'h37 + {4'd0, n});
    endfunction

    function automatic logic [CHAR_W-1:0] bcd2char(input logic [3:0] d);
        return ZERO + {4'd0, d};
    endfunction

    // Characters past the end of the banner text are padding.
    function automatic logic [CHAR_W-1:0] banner_char(input int unsigned idx);
        logic [CHAR_W*BANNER_LEN-1:0] sh;
        sh = BANNER_STR << (CHAR_W * idx);
        return (idx < BANNER_LEN) ? sh[CHAR_W*BANNER_LEN-1 -: CHAR_W] : SPACE;
    endfunction

endpackage

// File: rtl/bcd_decade.sv
// rtl/bcd_decade.sv - one BCD decade of the timestamp counter, carrying out on 9 -> 0
module bcd_decade (
    input  logic       clk_debug,
    input  logic       rst,
    input  logic       inc_in,
    output logic [3:0] digit,
    output logic       carry_out
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (inc_in) begin
            digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk_debug) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit     = digit_q;
    assign carry_out = inc_in && (digit_q == 4'd9);

endmodule

// File: rtl/debug_frame_gen.sv
// rtl/debug_frame_gen.sv - periodic ASCII debug frame builder with BCD timestamp and busy throttling
// Optional hex status field enabled by defining DEBUG_HEXFIELD_EN.
module debug_frame_gen
    import debug_pkg::*;
#(
    parameter int DIGITS    = 5,
    parameter int MSG_CHARS = 16,
    parameter int DROP_W    = 8
) (
    input  logic                      clk_debug,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      busy,
    input  logic [15:0]               data,
    output logic [CHAR_W*MSG_CHARS-1:0] msg,
    output logic                      send,
    output logic                      overrun,
    output logic [DROP_W-1:0]         drop_cnt
);

    localparam logic [CHAR_W*MSG_CHARS-1:0] IDLE_FRAME = {{(MSG_CHARS-1){SPACE}}, CR};

    state_e                      state_q, state_d;
    logic                        busy_m_q, busy_s_q;
    logic [CHAR_W*MSG_CHARS-1:0] msg_q, msg_d;
    logic                        send_q, send_d;
    logic                        overrun_q, overrun_d;
    logic [DROP_W-1:0]           drop_q, drop_d;
    logic                        tick;
    logic [3:0]                  dig [DIGITS];
    logic [DIGITS-2:0]           lead_nz;
    logic                        seen;
    logic [CHAR_W*MSG_CHARS-1:0] frame_w;
    logic [CHAR_W*MSG_CHARS-1:0] banner_w;

    // Timestamp: digit 0 is tenths; each decade ripples its carry into the next.
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        logic inc;
        logic carry;
        if (i == 0) begin : g_lsd
            assign inc = tick;
        end else begin : g_upper
            assign inc = g_dig[i-1].carry;
        end
        bcd_decade u_decade (
            .clk_debug (clk_debug),
            .rst       (rst),
            .inc_in    (inc),
            .digit     (dig[i]),
            .carry_out (carry)
        );
    end

    logic unused_wrap;
    assign unused_wrap = g_dig[DIGITS-1].carry;

    // lead_nz[c]: some digit at or above char c's digit is non-zero.
    always_comb begin
        seen    = 1'b0;
        lead_nz = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            seen = seen | (dig[i] != 4'd0);
            lead_nz[DIGITS-1-i] = seen;
        end
    end

    for (genvar c = 0; c < MSG_CHARS; c++) begin : g_chr
        logic [CHAR_W-1:0] ch;
        if (c < DIGITS - 1) begin : g_int
            assign ch = (lead_nz[c] || (c == DIGITS - 2)) ? bcd2char(dig[DIGITS-1-c]) : SPACE;
        end else if (c == DIGITS - 1) begin : g_dot
            assign ch = DOT;
        end else if (c == DIGITS) begin : g_tenths
            assign ch = bcd2char(dig[0]);
`ifdef DEBUG_HEXFIELD_EN
        end else if ((c >= DIGITS + 2) && (c <= DIGITS + 5)) begin : g_hex
            assign ch = nib2hex(data[4*(DIGITS+5-c) +: 4]);
`endif
        end else if (c == MSG_CHARS - 1) begin : g_cr
            assign ch = CR;
        end else begin : g_pad
            assign ch = SPACE;
        end
        assign frame_w[CHAR_W*(MSG_CHARS-1-c) +: CHAR_W]  = ch;
        assign banner_w[CHAR_W*(MSG_CHARS-1-c) +: CHAR_W] = (c == MSG_CHARS - 1) ? CR : banner_char(c);
    end

`ifndef DEBUG_HEXFIELD_EN
    logic unused_data;
    assign unused_data = ^data;
`endif

    always_ff @(posedge clk_debug) begin
        if (rst) begin
            state_q   <= BANNER;
            busy_m_q  <= 1'b0;
            busy_s_q  <= 1'b0;
            msg_q     <= IDLE_FRAME;
            send_q    <= 1'b0;
            overrun_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_m_q  <= busy;
            busy_s_q  <= busy_m_q;
            msg_q     <= msg_d;
            send_q    <= send_d;
            overrun_q <= overrun_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BANNER:  if (en && !busy_s_q) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BANNER;
        endcase
    end

    always_comb begin
        msg_d     = msg_q;
        send_d    = 1'b0;
        overrun_d = overrun_q;
        drop_d    = drop_q;
        tick      = 1'b0;
        case (state_q)
            BANNER: begin
                if (en && !busy_s_q) begin
                    msg_d  = banner_w;
                    send_d = 1'b1;
                end
            end
            RUN: begin
                if (en) begin
                    tick = 1'b1;
                    if (!busy_s_q) begin
                        msg_d  = frame_w;
                        send_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                        if (drop_q != '1) drop_d = drop_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign msg      = msg_q;
    assign send     = send_q;
    assign overrun  = overrun_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_debug_frame_gen.sv
// tb/tb_debug_frame_gen.sv - directed self-checking bench for debug_frame_gen
module tb_debug_frame_gen;

    logic         clk_debug = 1'b0;
    logic         rst = 1'b1, en = 1'b0, busy = 1'b0;
    logic         rst_w = 1'b1, en_w = 1'b0, busy_w = 1'b0;
    logic [15:0]  data = 16'hBEEF;
    logic [127:0] msg, msg_w;
    logic         send, send_w, overrun, overrun_w;
    logic [7:0]   drop_cnt, drop_cnt_w;
    int           passed = 0;
    int           total = 0;

    always #5 clk_debug = ~clk_debug;

    debug_frame_gen #(.DIGITS(5), .MSG_CHARS(16), .DROP_W(8)) dut (
        .clk_debug (clk_debug), .rst (rst), .en (en), .busy (busy), .data (data),
        .msg (msg), .send (send), .overrun (overrun), .drop_cnt (drop_cnt)
    );

    debug_frame_gen #(.DIGITS(3), .MSG_CHARS(16), .DROP_W(8)) dut_w (
        .clk_debug (clk_debug), .rst (rst_w), .en (en_w), .busy (busy_w), .data (data),
        .msg (msg_w), .send (send_w), .overrun (overrun_w), .drop_cnt (drop_cnt_w)
    );

    function automatic logic [127:0] frame(input string s);
        logic [127:0] f;
        for (int c = 0; c < 16; c++) f[8*(15-c) +: 8] = (c < s.len()) ? s[c] : 8'h20;
        f[7:0] = 8'h0D;
        return f;
    endfunction

    function automatic logic [127:0] ts_frame(input string ts);
`ifdef DEBUG_HEXFIELD_EN
        return frame({ts, " BEEF"});
`else
        return frame(ts);
`endif
    endfunction

    task automatic step;
        @(posedge clk_debug);
        @(negedge clk_debug);
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; busy = 1'b0;
        step; step;
        total++;
        if (msg !== frame("") || send !== 1'b0) $display("FAIL reset_msg send=%b msg=%h exp=%h", send, msg, frame(""));
        else passed++;
        total++;
        if (overrun !== 1'b0 || drop_cnt !== 8'd0) $display("FAIL reset_flags overrun=%b drop=%0d exp 0/0", overrun, drop_cnt);
        else passed++;
    endtask

    task automatic test_banner_first;
        rst = 1'b0; en = 1'b1;
        step;
        total++;
        if (send !== 1'b1 || msg !== frame("AVIONICS START")) $display("FAIL banner send=%b msg=%h exp=%h", send, msg, frame("AVIONICS START"));
        else passed++;
        step;
        total++;
        if (send !== 1'b1 || msg !== ts_frame("   0.0")) $display("FAIL frame_0_0 send=%b msg=%h exp=%h", send, msg, ts_frame("   0.0"));
        else passed++;
        step;
        total++;
        if (send !== 1'b1 || msg !== ts_frame("   0.1")) $display("FAIL frame_0_1 send=%b msg=%h exp=%h", send, msg, ts_frame("   0.1"));
        else passed++;
    endtask

    task automatic test_carry;
        int nsend = 0;
        for (int i = 0; i < 97; i++) begin
            step;
            nsend += int'(send);
        end
        total++;
        if (nsend !== 97) $display("FAIL run_sends got=%0d exp=97", nsend);
        else passed++;
        step;
        total++;
        if (send !== 1'b1 || msg !== ts_frame("   9.9")) $display("FAIL frame_9_9 send=%b msg=%h exp=%h", send, msg, ts_frame("   9.9"));
        else passed++;
        step;
        total++;
        if (send !== 1'b1 || msg !== ts_frame("  10.0")) $display("FAIL frame_10_0 send=%b msg=%h exp=%h", send, msg, ts_frame("  10.0"));
        else passed++;
    endtask

    task automatic test_drop;
        int nsend = 0;
        busy = 1'b1;
        step;
        total++;
        if (send !== 1'b1 || msg !== ts_frame("  10.1")) $display("FAIL sync_lat1 send=%b msg=%h exp=%h", send, msg, ts_frame("  10.1"));
        else passed++;
        step;
        total++;
        if (send !== 1'b1 || msg !== ts_frame("  10.2")) $display("FAIL sync_lat2 send=%b msg=%h exp=%h", send, msg, ts_frame("  10.2"));
        else passed++;
        for (int i = 0; i < 3; i++) begin step; nsend += int'(send); end
        busy = 1'b0;
        for (int i = 0; i < 2; i++) begin step; nsend += int'(send); end
        total++;
        if (nsend !== 0) $display("FAIL drop_no_send got=%0d exp=0", nsend);
        else passed++;
        total++;
        if (drop_cnt !== 8'd5 || overrun !== 1'b1) $display("FAIL drop_count drop=%0d overrun=%b exp 5/1", drop_cnt, overrun);
        else passed++;
        total++;
        if (msg !== ts_frame("  10.2")) $display("FAIL drop_hold msg=%h exp=%h", msg, ts_frame("  10.2"));
        else passed++;
        step;
        total++;
        if (send !== 1'b1 || msg !== ts_frame("  10.8")) $display("FAIL drop_jump send=%b msg=%h exp=%h", send, msg, ts_frame("  10.8"));
        else passed++;
    endtask

    task automatic test_saturate;
        int nsend = 0;
        busy = 1'b1;
        for (int i = 0; i < 300; i++) begin step; nsend += int'(send); end
        busy = 1'b0;
        for (int i = 0; i < 2; i++) begin step; nsend += int'(send); end
        total++;
        if (nsend !== 2) $display("FAIL sat_sends got=%0d exp=2", nsend);
        else passed++;
        total++;
        if (drop_cnt !== 8'hFF) $display("FAIL sat_drop got=%0d exp=255", drop_cnt);
        else passed++;
        step;
        total++;
        if (send !== 1'b1 || msg !== ts_frame("  41.1")) $display("FAIL sat_resume send=%b msg=%h exp=%h", send, msg, ts_frame("  41.1"));
        else passed++;
    endtask

    task automatic test_enable;
        int nsend = 0;
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin step; nsend += int'(send); end
        total++;
        if (nsend !== 0 || msg !== ts_frame("  41.1")) $display("FAIL en_hold sends=%0d msg=%h exp=%h", nsend, msg, ts_frame("  41.1"));
        else passed++;
        en = 1'b1;
        step;
        total++;
        if (send !== 1'b1 || msg !== ts_frame("  41.2") || drop_cnt !== 8'hFF) $display("FAIL en_resume send=%b drop=%0d msg=%h exp=%h", send, drop_cnt, msg, ts_frame("  41.2"));
        else passed++;
    endtask

    task automatic test_reset_mid;
        int  nsend = 0;
        bit  got = 1'b0;
        rst = 1'b1;
        step;
        total++;
        if (msg !== frame("") || send !== 1'b0 || overrun !== 1'b0 || drop_cnt !== 8'd0)
            $display("FAIL mid_reset send=%b overrun=%b drop=%0d msg=%h exp=%h", send, overrun, drop_cnt, msg, frame(""));
        else passed++;
        rst = 1'b0; en = 1'b0; busy = 1'b1;
        step; step;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin step; nsend += int'(send); end
        total++;
        if (nsend !== 0 || drop_cnt !== 8'd0) $display("FAIL banner_wait sends=%0d drop=%0d exp 0/0", nsend, drop_cnt);
        else passed++;
        busy = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin step; got = send; end
        total++;
        if (!got || msg !== frame("AVIONICS START") || drop_cnt !== 8'd0) $display("FAIL banner_resend got=%b drop=%0d msg=%h exp=%h", got, drop_cnt, msg, frame("AVIONICS START"));
        else passed++;
        step;
        total++;
        if (send !== 1'b1 || msg !== ts_frame("   0.0")) $display("FAIL post_reset_frame send=%b msg=%h exp=%h", send, msg, ts_frame("   0.0"));
        else passed++;
    endtask

    task automatic test_wrap;
        int nsend = 0;
        rst_w = 1'b0; en_w = 1'b1;
        step;
        total++;
        if (send_w !== 1'b1 || msg_w !== frame("AVIONICS START")) $display("FAIL wrap_banner send=%b msg=%h", send_w, msg_w);
        else passed++;
        for (int i = 0; i < 999; i++) begin step; nsend += int'(send_w); end
        total++;
        if (nsend !== 999) $display("FAIL wrap_sends got=%0d exp=999", nsend);
        else passed++;
        step;
        total++;
        if (send_w !== 1'b1 || msg_w !== ts_frame("99.9")) $display("FAIL wrap_max send=%b msg=%h exp=%h", send_w, msg_w, ts_frame("99.9"));
        else passed++;
        step;
        total++;
        if (send_w !== 1'b1 || msg_w !== ts_frame(" 0.0") || overrun_w !== 1'b0 || drop_cnt_w !== 8'd0)
            $display("FAIL wrap_zero send=%b overrun=%b drop=%0d msg=%h exp=%h", send_w, overrun_w, drop_cnt_w, msg_w, ts_frame(" 0.0"));
        else passed++;
    endtask

    initial begin
        test_reset;
        test_banner_first;
        test_carry;
        test_drop;
        test_saturate;
        test_enable;
        test_reset_mid;
        test_wrap;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
